// File: rtl/gpio_pkg.sv
// Shared types and default parameters for the GPIO input-conditioning path.
// No datapath here; nothing to stall.
package gpio_pkg;

  localparam int NUM_IO_DEF      = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_W_DEF       = 16;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'd0,
    IRQ_RISE = 2'd1,
    IRQ_FALL = 2'd2,
    IRQ_BOTH = 2'd3
  } gpio_irq_mode_e;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_e;

  function automatic logic edge_selected(gpio_irq_mode_e mode, logic rising);
    if (rising) return (mode == IRQ_RISE) || (mode == IRQ_BOTH);
    else        return (mode == IRQ_FALL) || (mode == IRQ_BOTH);
  endfunction

endpackage

// File: rtl/gpio_debounce_if.sv
// Pad-side controls and conditioned outputs of gpio_debounce, bundled per instance.
// Plain level/pulse signals, no handshake: the debouncer never backpressures.
interface gpio_debounce_if #(
  parameter int NUM_IO = gpio_pkg::NUM_IO_DEF,
  parameter int DEB_W  = gpio_pkg::DEB_W_DEF
);

  logic [NUM_IO-1:0]   pin_raw_i;
  logic [DEB_W-1:0]    deb_cycles_i;
  logic [2*NUM_IO-1:0] irq_mode_i;
  logic [NUM_IO-1:0]   irq_mask_i;
  logic [NUM_IO-1:0]   irq_clr_i;
  logic [NUM_IO-1:0]   pin_o;
  logic [NUM_IO-1:0]   rise_o;
  logic [NUM_IO-1:0]   fall_o;
  logic [NUM_IO-1:0]   irq_pending_o;
  logic                irq_o;

  modport master (
    output pin_raw_i, deb_cycles_i, irq_mode_i, irq_mask_i, irq_clr_i,
    input  pin_o, rise_o, fall_o, irq_pending_o, irq_o
  );

  modport slave (
    input  pin_raw_i, deb_cycles_i, irq_mode_i, irq_mask_i, irq_clr_i,
    output pin_o, rise_o, fall_o, irq_pending_o, irq_o
  );

endinterface

// File: rtl/gpio_deb_chan.sv
// One pin: synchronizer, stability filter, edge pulses and sticky pending bit.
// pin_o lags the pad by SYNC_STAGES+N-1 edges; no backpressure, sampled every cycle.
module gpio_deb_chan
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pin_raw,
  input  logic [DEB_W-1:0] i_deb_cycles,
  input  logic [1:0]       i_irq_mode,
  input  logic             i_irq_clr,
  output logic             o_pin,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_pending
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic             r_q;
  logic             w_q_nxt;
  logic [DEB_W-1:0] r_cnt;
  logic [DEB_W-1:0] w_cnt_nxt;
  logic [DEB_W:0]   w_cnt_inc;
  logic [DEB_W:0]   w_thresh;
  logic             w_s;
  logic             w_accept;
  logic             w_set;
  logic             r_rise;
  logic             r_fall;
  logic             r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // One extra bit so cnt+1 and the threshold compare without overflow.
  assign w_cnt_inc = {1'b0, r_cnt} + {{DEB_W{1'b0}}, 1'b1};
  assign w_thresh  = (i_deb_cycles == '0) ? {{DEB_W{1'b0}}, 1'b1} : {1'b0, i_deb_cycles};

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_STABLE, ST_CHANGING: begin
        if (w_s == r_q) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= w_thresh) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_STABLE;
          w_q_nxt     = w_s;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_CHANGING;
          w_cnt_nxt   = w_cnt_inc[DEB_W-1:0];
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_set = w_accept && edge_selected(gpio_irq_mode_e'(i_irq_mode), w_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_q     <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_accept & w_s;
      r_fall  <= w_accept & ~w_s;
      // A new event beats a simultaneous software clear.
      r_pend  <= w_set | (r_pend & ~i_irq_clr);
    end
  end

  assign o_pin     = r_q;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pend;

endmodule

// File: rtl/gpio_debounce.sv
// Debounces NUM_IO pad inputs and merges masked pending flags into irq_o.
// Latency SYNC_STAGES+N-1 edges to pin_o; no backpressure.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int NUM_IO      = NUM_IO_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_debounce_if.slave   gpio
);

  logic [NUM_IO-1:0] w_pin;
  logic [NUM_IO-1:0] w_rise;
  logic [NUM_IO-1:0] w_fall;
  logic [NUM_IO-1:0] w_pend;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_chan
    gpio_deb_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_pin_raw    (gpio.pin_raw_i[g]),
      .i_deb_cycles (gpio.deb_cycles_i),
      .i_irq_mode   (gpio.irq_mode_i[2*g +: 2]),
      .i_irq_clr    (gpio.irq_clr_i[g]),
      .o_pin        (w_pin[g]),
      .o_rise       (w_rise[g]),
      .o_fall       (w_fall[g]),
      .o_pending    (w_pend[g])
    );
  end

  assign gpio.pin_o         = w_pin;
  assign gpio.rise_o        = w_rise;
  assign gpio.fall_o        = w_fall;
  assign gpio.irq_pending_o = w_pend;
  // Mask gates only the summary line, so unmasking a held flag fires at once.
  assign gpio.irq_o         = |(w_pend & gpio.irq_mask_i);

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: latency, glitch rejection, IRQ set/clear/mask, threshold changes, reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_gpio_debounce;

  localparam int NIO = 2;
  localparam int SS  = 2;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gpio_debounce_if #(.NUM_IO(NIO), .DEB_W(DW)) u_if ();

  gpio_debounce #(
    .NUM_IO      (NIO),
    .SYNC_STAGES (SS),
    .DEB_W       (DW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gpio  (u_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_all();
    u_if.irq_clr_i = '1;
    ticks(1);
    u_if.irq_clr_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({u_if.pin_o, u_if.rise_o, u_if.fall_o, u_if.irq_pending_o, u_if.irq_o}), 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    u_if.pin_raw_i    = '0;
    u_if.deb_cycles_i = 16'd4;
    u_if.irq_mode_i   = 4'b11_01;
    u_if.irq_mask_i   = '0;
    u_if.irq_clr_i    = '0;
    ticks(3);
    check_val("rst_pin",  32'(u_if.pin_o), 0);
    check_val("rst_rise", 32'(u_if.rise_o), 0);
    check_val("rst_fall", 32'(u_if.fall_o), 0);
    check_val("rst_pend", 32'(u_if.irq_pending_o), 0);
    check_val("rst_irq",  32'(u_if.irq_o), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      check_all_zero("idle_out");
    end

    // pin0 rise, N=4: visible 6 falling edges after the drive point (edge k+5)
    u_if.pin_raw_i[0] = 1'b1;
    ticks(5);
    check_val("rise_early_pin0", 32'(u_if.pin_o[0]), 0);
    ticks(1);
    check_val("rise_pin0",       32'(u_if.pin_o[0]), 1);
    check_val("rise_pulse0",     32'(u_if.rise_o), 32'h1);
    check_val("rise_pend0",      32'(u_if.irq_pending_o), 32'h1);
    check_val("rise_irq_masked", 32'(u_if.irq_o), 0);
    ticks(1);
    check_val("rise_pulse_end",  32'(u_if.rise_o), 0);
    check_val("rise_pin0_hold",  32'(u_if.pin_o[0]), 1);
    clr_all();
    check_val("clr_pend", 32'(u_if.irq_pending_o), 0);

    // pin1 3-cycle glitch is rejected
    u_if.pin_raw_i[1] = 1'b1;
    ticks(3);
    u_if.pin_raw_i[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      check_val("glitch_pin1", 32'({u_if.pin_o[1], u_if.rise_o[1], u_if.irq_pending_o[1]}), 0);
    end

    // pin1 4-cycle pulse is accepted, then its fall follows
    u_if.pin_raw_i[1] = 1'b1;
    ticks(4);
    u_if.pin_raw_i[1] = 1'b0;
    ticks(2);
    check_val("pulse_pin1",  32'(u_if.pin_o[1]), 1);
    check_val("pulse_rise1", 32'(u_if.rise_o), 32'h2);
    check_val("pulse_pend1", 32'(u_if.irq_pending_o), 32'h2);
    ticks(4);
    check_val("pulse_fall_pin1", 32'(u_if.pin_o[1]), 0);
    check_val("pulse_fall1",     32'(u_if.fall_o), 32'h2);
    check_val("pulse_pend_hold", 32'(u_if.irq_pending_o), 32'h2);
    clr_all();

    // mode both, masked in: fall on pin0 raises irq_o
    u_if.irq_mode_i = 4'b11_11;
    u_if.irq_mask_i = 2'b01;
    u_if.pin_raw_i[0] = 1'b0;
    ticks(6);
    check_val("fall_pulse0", 32'(u_if.fall_o), 32'h1);
    check_val("fall_pin0",   32'(u_if.pin_o[0]), 0);
    check_val("fall_pend0",  32'(u_if.irq_pending_o), 32'h1);
    check_val("fall_irq",    32'(u_if.irq_o), 1);

    // clear coinciding with a new rise accept: set wins
    u_if.pin_raw_i[0] = 1'b1;
    ticks(5);
    u_if.irq_clr_i = 2'b01;
    ticks(1);
    u_if.irq_clr_i = 2'b00;
    check_val("setwin_rise", 32'(u_if.rise_o), 32'h1);
    check_val("setwin_pend", 32'(u_if.irq_pending_o), 32'h1);
    check_val("setwin_irq",  32'(u_if.irq_o), 1);
    clr_all();
    check_val("clr2_pend", 32'(u_if.irq_pending_o), 0);
    check_val("clr2_irq",  32'(u_if.irq_o), 0);

    // mask off still records pending; unmask is immediate
    u_if.irq_mask_i = 2'b00;
    u_if.pin_raw_i[0] = 1'b0;
    ticks(6);
    check_val("mask0_pend", 32'(u_if.irq_pending_o), 32'h1);
    check_val("mask0_irq",  32'(u_if.irq_o), 0);
    u_if.irq_mask_i = 2'b01;
    #1;
    check_val("unmask_irq", 32'(u_if.irq_o), 1);
    clr_all();
    check_val("clr3_irq", 32'(u_if.irq_o), 0);

    // N=1000, lowered to 10 at cnt=500; pin0 mode none
    u_if.irq_mode_i   = 4'b11_00;
    u_if.deb_cycles_i = 16'd1000;
    u_if.pin_raw_i[0] = 1'b1;
    ticks(502);
    check_val("long_wait_pin0", 32'(u_if.pin_o[0]), 0);
    u_if.deb_cycles_i = 16'd10;
    ticks(1);
    check_val("lower_pin0",  32'(u_if.pin_o[0]), 1);
    check_val("lower_rise0", 32'(u_if.rise_o), 32'h1);
    check_val("mode0_pend",  32'(u_if.irq_pending_o), 0);

    // deb_cycles 0 behaves as 1: pin_o changes at edge k+2
    u_if.deb_cycles_i = 16'd0;
    u_if.pin_raw_i[0] = 1'b0;
    ticks(2);
    check_val("n0_early", 32'(u_if.pin_o[0]), 1);
    ticks(1);
    check_val("n0_pin0",  32'(u_if.pin_o[0]), 0);
    check_val("n0_fall0", 32'(u_if.fall_o), 32'h1);
    u_if.deb_cycles_i = 16'd1;
    u_if.pin_raw_i[0] = 1'b1;
    ticks(2);
    check_val("n1_early", 32'(u_if.pin_o[0]), 0);
    ticks(1);
    check_val("n1_pin0",  32'(u_if.pin_o[0]), 1);
    check_val("n1_rise0", 32'(u_if.rise_o), 32'h1);

    // simultaneous opposite events on both pins
    u_if.deb_cycles_i = 16'd4;
    u_if.irq_mode_i   = 4'b11_11;
    u_if.pin_raw_i    = 2'b10;
    ticks(6);
    check_val("both_pin",  32'(u_if.pin_o), 32'h2);
    check_val("both_rise", 32'(u_if.rise_o), 32'h2);
    check_val("both_fall", 32'(u_if.fall_o), 32'h1);
    check_val("both_pend", 32'(u_if.irq_pending_o), 32'h3);
    clr_all();

    // reset mid-count, pad held high through reset
    u_if.pin_raw_i = 2'b01;
    ticks(3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_out");
    ticks(1);
    rst_n = 1'b1;
    ticks(5);
    check_val("post_rst_early", 32'(u_if.pin_o), 0);
    ticks(1);
    check_val("post_rst_pin",  32'(u_if.pin_o), 32'h1);
    check_val("post_rst_rise", 32'(u_if.rise_o), 32'h1);
    check_val("post_rst_pend", 32'(u_if.irq_pending_o), 32'h1);
    check_val("post_rst_irq",  32'(u_if.irq_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input conditioning stage that sits directly upstream of the GPIO peripheral's `io_pin_i`. For each raw pad input it applies a multi-flop synchronizer and a programmable stability filter (debounce). It drives the clean level to the GPIO block and generates per-pin edge events with a maskable, sticky interrupt.

## Interface
Parameters:
- `NUM_IO`, default 2: number of pad inputs handled.
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal values are 2 or more.
- `DEB_W`, default 16: width of the debounce counter and threshold.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `pin_raw_i`, input, NUM_IO: asynchronous pad levels.
- `deb_cycles_i`, input, DEB_W: stability threshold N in clk cycles; 0 is treated as 1.
- `irq_mode_i`, input, 2*NUM_IO: two bits per pin. 0 = none, 1 = rise, 2 = fall, 3 = both.
- `irq_mask_i`, input, NUM_IO: 1 = pending bit may assert `irq_o`.
- `irq_clr_i`, input, NUM_IO: one-cycle pulse that clears the matching pending bit.
- `pin_o`, output, NUM_IO: debounced level; connects to the GPIO block's `io_pin_i`.
- `rise_o`, output, NUM_IO: one-cycle pulse when the debounced level goes 0→1.
- `fall_o`, output, NUM_IO: one-cycle pulse when the debounced level goes 1→0.
- `irq_pending_o`, output, NUM_IO: sticky event flags.
- `irq_o`, output, 1: OR of (`irq_pending_o` & `irq_mask_i`).

## Operation
- Per pin, the pipeline is: sync chain, then output `s`; a stable register `q`, driven onto `pin_o`; and counter `cnt`.
- The per-pin FSM has two states:
  - STABLE: `s == q`; `cnt` = 0.
  - CHANGING: `s != q`; `cnt` increments each cycle.
- STABLE→CHANGING on the first edge where `s != q`.
- CHANGING→STABLE without update if `s` returns to `q`. `cnt` is cleared and no event is produced, so glitches shorter than N are rejected.
- CHANGING accept: at an edge where `s != q` and `cnt + 1 >= N`, the block does the following:
  - sets `q <= s` and `cnt <= 0`;
  - pulses `rise_o` or `fall_o`;
  - sets the pending bit if `irq_mode_i` selects that edge.
- The accept test uses `>=`, so lowering `deb_cycles_i` mid-count accepts on the next edge. Raising it extends the count. `cnt` never wraps because it is compared before increment and cleared on accept.
- Pending bits are cleared by `irq_clr_i`. If set and clear occur in the same cycle, set wins.
- `irq_mode_i` = 0 still produces `rise_o`/`fall_o` pulses but never sets pending.
- Masking does not block the pending set. Unmasking a pending bit raises `irq_o` immediately.
- Pins are fully independent; simultaneous events on different pins are all recorded.

## Timing
- Reset values: all sync flops, `q`/`pin_o`, `cnt`, `rise_o`, `fall_o`, `irq_pending_o` and `irq_o` are 0.
- A pad held high through reset produces a normal rise event after the latency below. Software clears it.
- Latency: a new level first captured at edge k appears on `s` after edge k+SYNC_STAGES−1. `q` and `pin_o` update at edge k+SYNC_STAGES+N−1.
- With SYNC_STAGES=2 and N=1, `pin_o` changes 2 cycles after capture.
- `rise_o`/`fall_o` are registered and high for exactly the one cycle after the accepting edge, aligned with the new `pin_o`.
- `irq_pending_o` rises on the same edge as the pulse.
- `irq_o` is a combinational function of registered pending and the `irq_mask_i` input. It asserts in the same cycle as `irq_pending_o`.
- Reset asserted mid-count forces every register to 0 asynchronously. Counting restarts from STABLE after release.

## Structure
- Shared package `gpio_pkg`:
  - enum `gpio_irq_mode_e` with values IRQ_NONE, IRQ_RISE, IRQ_FALL, IRQ_BOTH;
  - the STABLE/CHANGING state enum;
  - the default-parameter constants.
- Sub-module `gpio_deb_chan`: one pin's sync chain, FSM, counter, edge pulses and pending bit. The top level instantiates it with a `generate` loop of NUM_IO copies and ORs the masked pending bits.
- The synchronizer flops carry the project's async-input attribute and are not shared between pins.

## Test plan
- Reset with `pin_raw_i`=0: all outputs are 0. Release reset and hold 20 cycles: outputs stay 0.
- N=4, pin0 0→1 captured at edge k: `pin_o[0]`=1 from edge k+5, `rise_o[0]` high for exactly 1 cycle, `pending[0]`=1 when mode=1.
- N=4, 3-cycle high glitch on pin1: `pin_o[1]` stays 0, with no pulse and no pending. A 4-cycle high pulse on pin1 is accepted.
- Mode=3, mask=1, debounced fall on pin0: `irq_o`=1. Pulse `irq_clr_i[0]` on the same cycle as a new rise accept: pending stays 1.
- Mask=0, event sets pending and `irq_o`=0. Then set mask=1: `irq_o`=1 in the same cycle.
- N=1000 mid-count at `cnt`=500, change `deb_cycles_i` to 10: accept on the next edge. `deb_cycles_i`=0 behaves exactly as 1.
